// File: rtl/div_sched_pkg.sv
// Shared types and helpers for the divider configuration scheduler.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STOP = 2'd1,
        LOAD = 2'd2,
        RUN  = 2'd3
    } sched_state_t;

    localparam int DW_DEFAULT = 32;
    localparam int MAX_REQ    = 16;

    // Index of the first set bit of vec at or after ptr, wrapping within n bits.
    // Returns ptr when vec has no set bit; callers qualify the result with |vec.
    function automatic logic [3:0] first_set_from(input logic [3:0] ptr,
                                                  input logic [MAX_REQ-1:0] vec,
                                                  input int n);
        logic [3:0] idx;
        logic       found;
        first_set_from = ptr;
        found          = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = 4'((int'(ptr) + i) % n);
            if (!found && (i < n) && vec[idx]) begin
                first_set_from = idx;
                found          = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
    import div_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] winner_oh,
    output logic [IW-1:0]    winner_idx,
    output logic             valid
);

    logic [MAX_REQ-1:0] req_ext;
    logic [3:0]         pick;

    // Widen to the helper's fixed width, pick, and decode to one-hot.
    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req;
        pick                 = first_set_from(4'(ptr), req_ext, N_REQ);
        valid                = |req;
        winner_idx           = IW'(pick);
        winner_oh            = '0;
        if (valid) begin
            winner_oh[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/div_cfg_scheduler.sv
// Shares one programmable clock divider between N_REQ requesters.
// Handshake: REQ[r] is a level request held (with DIV_VAL[r] stable) until the
// requester is done; GNT[r] high means the divider runs at r's ratio. Dropping
// REQ[r] releases (or aborts) the grant; GNT falls the cycle after.
module div_cfg_scheduler
    import div_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DW       = DW_DEFAULT,
    parameter int SETTLE   = 2,
    parameter int MAX_HOLD = 0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [N_REQ-1:0]    REQ,
    input  logic [N_REQ*DW-1:0] DIV_VAL,
    output logic [N_REQ-1:0]    GNT,
    output logic                BUSY,
    output logic [DW-1:0]       CUR_DIV,
    output logic [DW-1:0]       DIV_DIN,
    output logic                DIV_CONFIG,
    output logic                DIV_ENABLE,
    output logic [1:0]          dbg_state
);

    localparam int IW = $clog2(N_REQ);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int HW = $clog2(MAX_HOLD + 2);

    sched_state_t     state, state_n;
    logic [IW-1:0]    owner, owner_n, rr_ptr, rr_ptr_n, next_ptr;
    logic [DW-1:0]    val, val_n, cur_n, din_n, req_val, req_val_nz;
    logic [SW-1:0]    settle_cnt, settle_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic [N_REQ-1:0] gnt_n, arb_oh, owner_oh;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid, en_n, cfg_n, owner_req, others_waiting;
    logic [DW-1:0]    val_arr [N_REQ];

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req        (REQ),
        .ptr        (rr_ptr),
        .winner_oh  (arb_oh),
        .winner_idx (arb_idx),
        .valid      (arb_valid)
    );

    // Requested ratio of the arbitration winner (0 means 1) and owner status.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            val_arr[i] = DIV_VAL[i*DW +: DW];
        end
        req_val        = val_arr[arb_idx];
        req_val_nz     = (req_val == '0) ? DW'(1) : req_val;
        owner_oh       = N_REQ'(1) << owner;
        owner_req      = REQ[owner];
        others_waiting = |(REQ & ~owner_oh);
        next_ptr       = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
    end

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        val_n    = val;
        settle_n = settle_cnt;
        hold_n   = hold_cnt;
        gnt_n    = GNT;
        en_n     = DIV_ENABLE;
        cfg_n    = 1'b0;
        din_n    = DIV_DIN;
        cur_n    = CUR_DIV;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    owner_n = arb_idx;
                    val_n   = req_val_nz;
                    if ((req_val_nz == CUR_DIV) && DIV_ENABLE) begin
                        state_n = RUN;
                        gnt_n   = arb_oh;
                        hold_n  = HW'(1);
                    end else begin
                        state_n  = STOP;
                        en_n     = 1'b0;
                        settle_n = SW'(SETTLE - 1);
                    end
                end
            end
            STOP: begin
                en_n = 1'b0;
                if (!owner_req) begin
                    state_n  = IDLE;
                    rr_ptr_n = next_ptr;
                end else if (settle_cnt == '0) begin
                    state_n = LOAD;
                    cfg_n   = 1'b1;
                    din_n   = val;
                    cur_n   = val;
                end else begin
                    settle_n = settle_cnt - SW'(1);
                end
            end
            LOAD: begin
                // The strobe always completes; an abort only skips the grant.
                en_n = 1'b0;
                if (owner_req) begin
                    state_n = RUN;
                    en_n    = 1'b1;
                    gnt_n   = owner_oh;
                    hold_n  = HW'(1);
                end else begin
                    state_n  = IDLE;
                    rr_ptr_n = next_ptr;
                end
            end
            RUN: begin
                if (!owner_req ||
                    ((MAX_HOLD > 0) && (hold_cnt == HW'(MAX_HOLD)) && others_waiting)) begin
                    state_n  = IDLE;
                    gnt_n    = '0;
                    rr_ptr_n = next_ptr;
                end else if (hold_cnt < HW'(MAX_HOLD)) begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            val        <= DW'(1);
            settle_cnt <= '0;
            hold_cnt   <= '0;
            GNT        <= '0;
            DIV_ENABLE <= 1'b0;
            DIV_CONFIG <= 1'b0;
            DIV_DIN    <= '0;
            CUR_DIV    <= DW'(1);
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            rr_ptr     <= rr_ptr_n;
            val        <= val_n;
            settle_cnt <= settle_n;
            hold_cnt   <= hold_n;
            GNT        <= gnt_n;
            DIV_ENABLE <= en_n;
            DIV_CONFIG <= cfg_n;
            DIV_DIN    <= din_n;
            CUR_DIV    <= cur_n;
        end
    end

    assign BUSY      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_div_cfg_scheduler.sv
// Self-checking bench for div_cfg_scheduler.
module tb_div_cfg_scheduler;
    import div_sched_pkg::*;

    localparam int N_REQ    = 4;
    localparam int DW       = 32;
    localparam int SETTLE   = 2;
    localparam int MAX_HOLD = 8;
    localparam int EW       = N_REQ + DW;

    logic                CLK = 1'b0;
    logic                RESET;
    logic [N_REQ-1:0]    REQ;
    logic [N_REQ*DW-1:0] DIV_VAL;
    logic [N_REQ-1:0]    GNT;
    logic                BUSY;
    logic [DW-1:0]       CUR_DIV;
    logic [DW-1:0]       DIV_DIN;
    logic                DIV_CONFIG;
    logic                DIV_ENABLE;
    logic [1:0]          dbg_state;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0]    exp_gnt_q[$];
    logic [DW-1:0]    exp_cfg_q[$];
    logic [N_REQ-1:0] gnt_prev = '0;

    div_cfg_scheduler #(
        .N_REQ(N_REQ), .DW(DW), .SETTLE(SETTLE), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ        (REQ),
        .DIV_VAL    (DIV_VAL),
        .GNT        (GNT),
        .BUSY       (BUSY),
        .CUR_DIV    (CUR_DIV),
        .DIV_DIN    (DIV_DIN),
        .DIV_CONFIG (DIV_CONFIG),
        .DIV_ENABLE (DIV_ENABLE),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_val(input int r, input logic [DW-1:0] v);
        DIV_VAL[r*DW +: DW] = v;
    endtask

    task automatic expect_load(input logic [DW-1:0] din);
        exp_cfg_q.push_back(din);
    endtask

    task automatic expect_grant(input logic [N_REQ-1:0] g, input logic [DW-1:0] cur);
        exp_gnt_q.push_back({g, cur});
    endtask

    task automatic wait_grant(input int budget);
        for (int i = 0; i < budget && GNT == '0; i++) step();
        check("grant_wait", 64'(|GNT), 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_gnt"}, GNT, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_cur"}, CUR_DIV, 1);
        check({tag, "_din"}, DIV_DIN, 0);
        check({tag, "_cfg"}, DIV_CONFIG, 0);
        check({tag, "_en"}, DIV_ENABLE, 0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    // Scoreboard and invariant monitor, sampled on the falling edge
    always @(negedge CLK) begin
        check("inv_cfg_while_en", 64'(DIV_CONFIG & DIV_ENABLE), 0);
        check("inv_gnt_onehot", 64'($onehot0(GNT)), 1);
        check("inv_gnt_without_en", 64'((|GNT) & ~DIV_ENABLE), 0);
        if (DIV_CONFIG) begin
            check("cfg_pending", 64'(exp_cfg_q.size() > 0), 1);
            if (exp_cfg_q.size() > 0) check("cfg_din", DIV_DIN, exp_cfg_q.pop_front());
        end
        if (GNT != '0 && gnt_prev == '0) begin
            check("grant_pending", 64'(exp_gnt_q.size() > 0), 1);
            if (exp_gnt_q.size() > 0) check("grant_gnt_cur", {GNT, CUR_DIV}, exp_gnt_q.pop_front());
        end
        gnt_prev <= GNT;
    end

    initial begin
        int cnt;
        RESET   = 1'b1;
        REQ     = '0;
        DIV_VAL = '0;
        step();
        step();
        check_reset_state("reset");

        // Basic reload sequence: STOP x2, LOAD, RUN
        RESET = 1'b0;
        set_val(0, 4);
        REQ = 4'b0001;
        expect_load(4);
        expect_grant(4'b0001, 4);
        step();
        check("t1_stop_state", dbg_state, STOP);
        check("t1_stop_en", DIV_ENABLE, 0);
        check("t1_stop_busy", BUSY, 1);
        step();
        check("t1_stop2_cfg", DIV_CONFIG, 0);
        check("t1_stop2_state", dbg_state, STOP);
        step();
        check("t1_load_cfg", DIV_CONFIG, 1);
        check("t1_load_din", DIV_DIN, 4);
        check("t1_load_cur", CUR_DIV, 4);
        check("t1_load_en", DIV_ENABLE, 0);
        step();
        check("t1_run_gnt", GNT, 4'b0001);
        check("t1_run_en", DIV_ENABLE, 1);
        check("t1_run_cfg", DIV_CONFIG, 0);
        step();
        REQ = 4'b0000;
        step();
        check("t1_rel_gnt", GNT, 0);
        check("t1_rel_busy", BUSY, 0);
        check("t1_rel_en", DIV_ENABLE, 1);

        // Two requesters alternate; pointer wraps 3 -> 0
        set_val(0, 6);
        set_val(2, 6);
        REQ = 4'b0101;
        expect_load(6);
        expect_grant(4'b0100, 6);
        wait_grant(10);
        check("t2_first_gnt", GNT, 4'b0100);
        repeat (3) step();
        REQ = 4'b0001;
        expect_grant(4'b0001, 6);
        step();
        check("t2_rel2_gnt", GNT, 0);
        step();
        check("t2_wrap_gnt", GNT, 4'b0001);
        REQ = 4'b0101;
        repeat (3) step();
        REQ = 4'b0100;
        expect_grant(4'b0100, 6);
        step();
        check("t2_rel0_gnt", GNT, 0);
        step();
        check("t2_second_gnt", GNT, 4'b0100);
        REQ = 4'b0000;
        step();

        // Same ratio requested: direct grant, no reconfiguration
        set_val(0, 4);
        REQ = 4'b0001;
        expect_load(4);
        expect_grant(4'b0001, 4);
        wait_grant(10);
        repeat (2) step();
        set_val(2, 4);
        REQ = 4'b0100;
        expect_grant(4'b0100, 4);
        step();
        check("t3_rel_gnt", GNT, 0);
        step();
        check("t3_direct_gnt", GNT, 4'b0100);
        check("t3_direct_cfg", DIV_CONFIG, 0);
        REQ = 4'b0000;
        step();

        // Ratio 0 is loaded as 1
        set_val(1, 0);
        REQ = 4'b0010;
        expect_load(1);
        expect_grant(4'b0010, 1);
        wait_grant(10);
        check("t4_cur", CUR_DIV, 1);
        check("t4_din", DIV_DIN, 1);
        REQ = 4'b0000;
        step();

        // Abort during STOP
        set_val(3, 9);
        REQ = 4'b1000;
        step();
        check("t5a_stop_state", dbg_state, STOP);
        REQ = 4'b0000;
        step();
        check("t5a_idle_state", dbg_state, IDLE);
        check("t5a_en", DIV_ENABLE, 0);
        check("t5a_cur", CUR_DIV, 1);
        repeat (3) step();
        check("t5a_gnt", GNT, 0);

        // Abort during LOAD
        REQ = 4'b1000;
        expect_load(9);
        repeat (3) step();
        check("t5b_load_state", dbg_state, LOAD);
        check("t5b_load_cfg", DIV_CONFIG, 1);
        REQ = 4'b0000;
        step();
        check("t5b_idle_state", dbg_state, IDLE);
        check("t5b_cfg", DIV_CONFIG, 0);
        check("t5b_cur", CUR_DIV, 9);
        repeat (4) step();
        check("t5b_gnt", GNT, 0);
        check("t5b_en", DIV_ENABLE, 0);

        // Forced release after MAX_HOLD cycles with another requester waiting
        set_val(0, 5);
        set_val(1, 5);
        REQ = 4'b0011;
        expect_load(5);
        expect_grant(4'b0001, 5);
        wait_grant(10);
        expect_grant(4'b0010, 5);
        cnt = (GNT == 4'b0001) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (GNT == 4'b0001) cnt++;
            else break;
        end
        check("t6_hold_len", cnt, MAX_HOLD);
        check("t6_forced_gnt", GNT, 0);
        step();
        check("t6_next_gnt", GNT, 4'b0010);
        REQ = 4'b0000;
        step();

        // Asynchronous reset during LOAD
        set_val(2, 7);
        REQ = 4'b0100;
        expect_load(7);
        repeat (3) step();
        check("t7_load_cfg", DIV_CONFIG, 1);
        @(negedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        check_reset_state("t7_async");
        REQ = 4'b0000;
        step();
        step();
        RESET = 1'b0;
        step();
        check_reset_state("t7_after");

        check("exp_gnt_q_empty", exp_gnt_q.size(), 0);
        check("exp_cfg_q_empty", exp_cfg_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
